// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave backed by a 32 x 32-bit register memory.
//
// The decoded window holds two 16-word banks:
//   bank0 at BASE_ADDR + 0x000..0x03F
//   bank1 at BASE_ADDR + 0x100..0x13F
// An address outside both banks, or one that is not word aligned, gets a
// two-cycle ERROR response. OKAY data phases are stretched by WAIT_CYCLES
// wait states. The block also counts completed OKAY reads and writes.
//
// Ports
//   hclk_i    in   1   clock, all state changes on the rising edge
//   irst      in   1   synchronous active-high reset
//   hsel_i    in   1   slave select
//   haddr_i   in  32   address-phase address
//   htrans_i  in   2   transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   hwrite_i  in   1   1 = write, 0 = read
//   hwdata_i  in  32   write data (data phase)
//   hready_i  in   1   bus HREADY; the address phase is only sampled when high
//   hready_o  out  1   slave ready, low inserts a wait state
//   hresp_o   out  1   0 = OKAY, 1 = ERROR
//   hrdata_o  out 32   read data, zero outside a completing read
//   rd_cnt_o  out  8   completed OKAY reads (wraps)
//   wr_cnt_o  out  8   completed OKAY writes (wraps)

module ahb_slave_mem #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1A00
) (
    input  logic        hclk_i,
    input  logic        irst,
    input  logic        hsel_i,
    input  logic [31:0] haddr_i,
    input  logic [1:0]  htrans_i,
    input  logic        hwrite_i,
    input  logic [31:0] hwdata_i,
    input  logic        hready_i,
    output logic        hready_o,
    output logic        hresp_o,
    output logic [31:0] hrdata_o,
    output logic [7:0]  rd_cnt_o,
    output logic [7:0]  wr_cnt_o
);

    localparam logic [2:0] WAIT_LOAD = WAIT_CYCLES[2:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ERR1 = 2'd2,
        ERR2 = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  wait_cnt_reg, wait_cnt_next;
    logic [4:0]  idx_reg, idx_next;
    logic        write_reg, write_next;
    logic [7:0]  rd_cnt_reg, wr_cnt_reg;
    logic [31:0] mem_reg [32];

    logic        accept;
    logic        addr_valid;
    logic [4:0]  addr_idx;
    logic        can_accept;
    logic        done_ok;
    logic        ready_int;
    logic        resp_int;
    logic [31:0] rdata_int;

    // Only bit 1 of htrans distinguishes active transfers from IDLE/BUSY.
    logic        htrans_unused;
    assign htrans_unused = htrans_i[0];

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    assign accept     = hsel_i & hready_i & htrans_i[1];
    assign addr_valid = (haddr_i[31:9] == BASE_ADDR[31:9]) &&
                        (haddr_i[7:6] == 2'b00) &&
                        (haddr_i[1:0] == 2'b00);
    // Bit 8 selects the bank, bits 5:2 the word within it.
    assign addr_idx   = {haddr_i[8], haddr_i[5:2]};

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge hclk_i) begin
        if (irst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            idx_reg      <= '0;
            write_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            idx_reg      <= idx_next;
            write_reg    <= write_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        idx_next      = idx_reg;
        write_next    = write_reg;
        ready_int     = 1'b1;
        resp_int      = 1'b0;
        rdata_int     = '0;
        done_ok       = 1'b0;
        can_accept    = 1'b0;

        case (state_reg)
            IDLE: begin
                can_accept = 1'b1;
            end
            DATA: begin
                if (wait_cnt_reg != 3'd0) begin
                    ready_int     = 1'b0;
                    wait_cnt_next = wait_cnt_reg - 3'd1;
                end else begin
                    // Completing cycle: the next address phase overlaps it.
                    done_ok    = 1'b1;
                    can_accept = 1'b1;
                    state_next = IDLE;
                    if (!write_reg) begin
                        rdata_int = mem_reg[idx_reg];
                    end
                end
            end
            ERR1: begin
                ready_int  = 1'b0;
                resp_int   = 1'b1;
                state_next = ERR2;
            end
            ERR2: begin
                resp_int   = 1'b1;
                can_accept = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A new address phase is taken only in cycles where this slave is
        // itself ready, so a wait state can never swallow a transfer.
        if (can_accept && accept) begin
            idx_next   = addr_idx;
            write_next = hwrite_i;
            if (addr_valid) begin
                state_next    = DATA;
                wait_cnt_next = WAIT_LOAD;
            end else begin
                state_next    = ERR1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: cleared as a whole on reset, written at the end of a
    // completing write data phase.
    // ------------------------------------------------------------------
    always_ff @(posedge hclk_i) begin
        if (irst) begin
            for (int i = 0; i < 32; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (done_ok && write_reg) begin
            mem_reg[idx_reg] <= hwdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Completion counters (wrap naturally at 8 bits)
    // ------------------------------------------------------------------
    always_ff @(posedge hclk_i) begin
        if (irst) begin
            rd_cnt_reg <= '0;
            wr_cnt_reg <= '0;
        end else if (done_ok) begin
            if (write_reg) begin
                wr_cnt_reg <= wr_cnt_reg + 8'd1;
            end else begin
                rd_cnt_reg <= rd_cnt_reg + 8'd1;
            end
        end
    end

    assign hready_o = ready_int;
    assign hresp_o  = resp_int;
    assign hrdata_o = rdata_int;
    assign rd_cnt_o = rd_cnt_reg;
    assign wr_cnt_o = wr_cnt_reg;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem. Two instances share one bus: u_dut1 with
// one wait state and u_dut0 with none; sel0 routes hsel and the readback to
// one of them. A pipelined master walks a table of transfers and records
// what each data phase saw.

module tb_ahb_slave_mem;

    localparam int MAXQ = 300;

    logic        clk = 1'b0;
    logic        irst;
    logic        hsel_bus;
    logic        sel0;
    logic        block_rdy;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;

    logic        hsel0, hsel1;
    logic        hready_in0, hready_in1;
    logic        hready0, hready1, hresp0, hresp1;
    logic [31:0] hrdata0, hrdata1;
    logic [7:0]  rd0, wr0, rd1, wr1;

    logic        hready, hresp;
    logic [31:0] hrdata;
    logic [7:0]  rd_cnt, wr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign hsel0      = hsel_bus & sel0;
    assign hsel1      = hsel_bus & ~sel0;
    assign hready_in0 = hready0 & ~block_rdy;
    assign hready_in1 = hready1 & ~block_rdy;
    assign hready     = sel0 ? hready0 : hready1;
    assign hresp      = sel0 ? hresp0  : hresp1;
    assign hrdata     = sel0 ? hrdata0 : hrdata1;
    assign rd_cnt     = sel0 ? rd0     : rd1;
    assign wr_cnt     = sel0 ? wr0     : wr1;

    ahb_slave_mem #(.WAIT_CYCLES(0), .BASE_ADDR(32'h0000_1A00)) u_dut0 (
        .hclk_i(clk), .irst(irst), .hsel_i(hsel0), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hwdata_i(hwdata),
        .hready_i(hready_in0), .hready_o(hready0), .hresp_o(hresp0),
        .hrdata_o(hrdata0), .rd_cnt_o(rd0), .wr_cnt_o(wr0)
    );

    ahb_slave_mem #(.WAIT_CYCLES(1), .BASE_ADDR(32'h0000_1A00)) u_dut1 (
        .hclk_i(clk), .irst(irst), .hsel_i(hsel1), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hwdata_i(hwdata),
        .hready_i(hready_in1), .hready_o(hready1), .hresp_o(hresp1),
        .hrdata_o(hrdata1), .rd_cnt_o(rd1), .wr_cnt_o(wr1)
    );

    // Transfer table and per-transfer observations
    logic [31:0] q_addr  [MAXQ];
    logic        q_wr    [MAXQ];
    logic [31:0] q_wdata [MAXQ];
    logic [1:0]  q_trans [MAXQ];
    int          q_n;
    int          r_waits [MAXQ];
    logic        r_wresp [MAXQ];
    logic [31:0] r_wrdata[MAXQ];
    logic        r_resp  [MAXQ];
    logic [31:0] r_rdata [MAXQ];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic q_clear();
        q_n = 0;
    endtask

    task automatic q_push(input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [1:0] trans);
        q_addr[q_n]  = addr;
        q_wr[q_n]    = wr;
        q_wdata[q_n] = wdata;
        q_trans[q_n] = trans;
        q_n++;
    endtask

    // Pipelined master; entered and left #1 after a rising edge.
    task automatic run_q();
        int   ai;
        int   di;
        int   cyc;
        logic rdy;
        ai  = 0;
        di  = -1;
        cyc = 0;
        for (int i = 0; i < q_n; i++) begin
            r_waits[i]  = 0;
            r_wresp[i]  = 1'b0;
            r_wrdata[i] = '0;
            r_resp[i]   = 1'b0;
            r_rdata[i]  = '0;
        end
        while (ai < q_n || di >= 0) begin
            if (cyc >= 2000) begin
                check_val("run_q_timeout", 32'(q_n - ai + ((di >= 0) ? 1 : 0)), 32'd0);
                break;
            end
            cyc++;
            if (ai < q_n) begin
                hsel_bus = 1'b1;
                haddr    = q_addr[ai];
                htrans   = q_trans[ai];
                hwrite   = q_wr[ai];
            end else begin
                hsel_bus = 1'b0;
                haddr    = '0;
                htrans   = 2'b00;
                hwrite   = 1'b0;
            end
            hwdata = (di >= 0 && q_wr[di]) ? q_wdata[di] : 32'd0;
            @(negedge clk);
            rdy = hready;
            if (di >= 0) begin
                if (!rdy) begin
                    r_waits[di]++;
                    r_wresp[di]  = r_wresp[di] | hresp;
                    r_wrdata[di] = r_wrdata[di] | hrdata;
                end else begin
                    r_resp[di]  = hresp;
                    r_rdata[di] = hrdata;
                    $display("xfer %0d addr=%h trans=%b wr=%0d waits=%0d resp=%0d rdata=%h",
                             di, q_addr[di], q_trans[di], q_wr[di], r_waits[di], hresp, hrdata);
                end
            end
            sync();
            if (rdy) begin
                if (ai < q_n) begin
                    di = ai;
                    ai++;
                end else begin
                    di = -1;
                end
            end
        end
        hsel_bus = 1'b0;
        haddr    = '0;
        htrans   = 2'b00;
        hwrite   = 1'b0;
        hwdata   = '0;
    endtask

    task automatic check_xfer(input string tag, input int i, input int exp_waits,
                              input logic exp_err, input logic [31:0] exp_rdata);
        check_val($sformatf("%s_waits", tag), 32'(r_waits[i]), 32'(exp_waits));
        check_val($sformatf("%s_wait_resp", tag), {31'd0, r_wresp[i]},
                  {31'd0, (exp_waits > 0) ? exp_err : 1'b0});
        check_val($sformatf("%s_wait_rdata", tag), r_wrdata[i], 32'd0);
        check_val($sformatf("%s_resp", tag), {31'd0, r_resp[i]}, {31'd0, exp_err});
        check_val($sformatf("%s_rdata", tag), r_rdata[i], exp_rdata);
    endtask

    task automatic check_cnts(input string tag, input int exp_rd, input int exp_wr);
        check_val($sformatf("%s_rd_cnt", tag), {24'd0, rd_cnt}, 32'(exp_rd));
        check_val($sformatf("%s_wr_cnt", tag), {24'd0, wr_cnt}, 32'(exp_wr));
    endtask

    initial begin
        int idle_bad;
        irst      = 1'b1;
        hsel_bus  = 1'b0;
        sel0      = 1'b0;
        block_rdy = 1'b0;
        haddr     = '0;
        htrans    = 2'b00;
        hwrite    = 1'b0;
        hwdata    = '0;
        q_n       = 0;
        repeat (3) @(posedge clk);
        #1;
        irst = 1'b0;

        // Reset state of both instances
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel0 = (k == 0);
            #0;
            check_val($sformatf("rst%0d_hready", k), {31'd0, hready}, 32'd1);
            check_val($sformatf("rst%0d_hresp", k), {31'd0, hresp}, 32'd0);
            check_val($sformatf("rst%0d_hrdata", k), hrdata, 32'd0);
            check_cnts($sformatf("rst%0d", k), 0, 0);
        end
        sel0 = 1'b0;
        sync();

        // Single read with one wait state
        q_clear();
        q_push(32'h1A04, 1'b0, 32'd0, 2'b10);
        run_q();
        check_xfer("single_rd", 0, 1, 1'b0, 32'd0);
        check_cnts("single_rd", 1, 0);

        // Zero-wait back-to-back burst: writes then readback
        sel0 = 1'b1;
        q_clear();
        q_push(32'h1B00, 1'b1, 32'h11, 2'b10);
        q_push(32'h1B04, 1'b1, 32'h22, 2'b11);
        q_push(32'h1B08, 1'b1, 32'h33, 2'b11);
        q_push(32'h1B0C, 1'b1, 32'h44, 2'b11);
        q_push(32'h1B00, 1'b0, 32'd0, 2'b10);
        q_push(32'h1B04, 1'b0, 32'd0, 2'b11);
        q_push(32'h1B08, 1'b0, 32'd0, 2'b11);
        q_push(32'h1B0C, 1'b0, 32'd0, 2'b11);
        run_q();
        check_xfer("burst_w0", 0, 0, 1'b0, 32'd0);
        check_xfer("burst_w3", 3, 0, 1'b0, 32'd0);
        check_xfer("burst_r0", 4, 0, 1'b0, 32'h11);
        check_xfer("burst_r1", 5, 0, 1'b0, 32'h22);
        check_xfer("burst_r2", 6, 0, 1'b0, 32'h33);
        check_xfer("burst_r3", 7, 0, 1'b0, 32'h44);
        check_cnts("burst", 4, 4);

        // Address phase with hready_i low must be ignored
        block_rdy = 1'b1;
        hsel_bus  = 1'b1;
        haddr     = 32'h1A08;
        htrans    = 2'b10;
        hwrite    = 1'b1;
        hwdata    = 32'h5A5A5A5A;
        sync();
        block_rdy = 1'b0;
        hsel_bus  = 1'b0;
        htrans    = 2'b00;
        hwrite    = 1'b0;
        sync();
        hwdata    = '0;
        @(negedge clk);
        check_val("ignored_hready", {31'd0, hready}, 32'd1);
        check_cnts("ignored", 4, 4);
        sync();
        q_clear();
        q_push(32'h1A08, 1'b0, 32'd0, 2'b10);
        run_q();
        check_xfer("ignored_rd", 0, 0, 1'b0, 32'd0);
        check_cnts("ignored_rd", 5, 4);

        // Errors pipelined into a valid read; index 0 must stay untouched
        sel0 = 1'b0;
        q_clear();
        q_push(32'h1A40, 1'b0, 32'd0, 2'b10);
        q_push(32'h2000, 1'b1, 32'hFFFF_FFFF, 2'b10);
        q_push(32'h1A00, 1'b0, 32'd0, 2'b10);
        run_q();
        check_xfer("err_rd", 0, 1, 1'b1, 32'd0);
        check_xfer("err_wr", 1, 1, 1'b1, 32'd0);
        check_xfer("err_after_rd", 2, 1, 1'b0, 32'd0);
        check_cnts("err", 2, 0);

        // Read-after-write to the same word
        q_clear();
        q_push(32'h1A3C, 1'b1, 32'hDEAD_BEEF, 2'b10);
        q_push(32'h1A3C, 1'b0, 32'd0, 2'b10);
        run_q();
        check_xfer("raw_wr", 0, 1, 1'b0, 32'd0);
        check_xfer("raw_rd", 1, 1, 1'b0, 32'hDEAD_BEEF);
        check_cnts("raw", 3, 1);

        // Reset in the wait state of a write
        q_clear();
        q_push(32'h1B04, 1'b1, 32'h1234_5678, 2'b10);
        q_push(32'h1B04, 1'b0, 32'd0, 2'b10);
        run_q();
        check_xfer("prerst_rd", 1, 1, 1'b0, 32'h1234_5678);
        check_cnts("prerst", 4, 2);
        hsel_bus = 1'b1;
        haddr    = 32'h1B04;
        htrans   = 2'b10;
        hwrite   = 1'b1;
        sync();
        hsel_bus = 1'b0;
        htrans   = 2'b00;
        hwrite   = 1'b0;
        hwdata   = 32'hCAFE_F00D;
        irst     = 1'b1;
        @(negedge clk);
        check_val("rst_mid_wait_hready", {31'd0, hready}, 32'd0);
        sync();
        irst = 1'b0;
        @(negedge clk);
        check_val("rst_mid_hready", {31'd0, hready}, 32'd1);
        check_val("rst_mid_hresp", {31'd0, hresp}, 32'd0);
        check_val("rst_mid_hrdata", hrdata, 32'd0);
        sync();
        hwdata = '0;
        q_clear();
        q_push(32'h1B04, 1'b0, 32'd0, 2'b10);
        run_q();
        check_xfer("rst_mid_rd", 0, 1, 1'b0, 32'd0);
        check_cnts("rst_mid", 1, 0);

        // Read counter wrap with IDLE/BUSY slots interleaved
        sel0 = 1'b1;
        q_clear();
        for (int i = 0; i < 255; i++) begin
            q_push(32'h1A00 + 32'((i % 16) * 4), 1'b0, 32'd0, (i % 2 == 0) ? 2'b10 : 2'b11);
            if (i % 32 == 31) begin
                q_push(32'h1A00, 1'b0, 32'd0, 2'b00);
                q_push(32'h1A04, 1'b1, 32'd0, 2'b01);
            end
        end
        run_q();
        idle_bad = 0;
        for (int i = 0; i < q_n; i++) begin
            if (!q_trans[i][1] && (r_waits[i] != 0 || r_resp[i] !== 1'b0 || r_rdata[i] !== 32'd0)) begin
                idle_bad++;
            end
        end
        check_val("wrap_idle_okay", 32'(idle_bad), 32'd0);
        check_cnts("wrap_255", 255, 0);
        q_clear();
        q_push(32'h1A00, 1'b0, 32'd0, 2'b01);
        q_push(32'h1A3C, 1'b0, 32'd0, 2'b10);
        q_push(32'h1A00, 1'b0, 32'd0, 2'b00);
        run_q();
        check_xfer("wrap_busy", 0, 0, 1'b0, 32'd0);
        check_xfer("wrap_last", 1, 0, 1'b0, 32'd0);
        check_xfer("wrap_idle", 2, 0, 1'b0, 32'd0);
        check_cnts("wrap_256", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, wait states inserted per OKAY data phase, legal range 0..7.
REQ-002 Parameter BASE_ADDR, default 32'h1A00, base of the decoded window; bits [8:0] are 0.
REQ-003 Port hclk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port irst  input  1  reset, synchronous and active-high.
REQ-005 Port hsel_i  input  1  slave select from the decoder.
REQ-006 Port haddr_i  input  32  address-phase address.
REQ-007 Port htrans_i  input  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-008 Port hwrite_i  input  1  1 = write, 0 = read.
REQ-009 Port hwdata_i  input  32  write data, valid in the data phase.
REQ-010 Port hready_i  input  1  bus-level HREADY; the address phase is sampled only when it is high.
REQ-011 Port hready_o  output  1  slave ready; low = wait state.
REQ-012 Port hresp_o  output  1  0 = OKAY, 1 = ERROR.
REQ-013 Port hrdata_o  output  32  read data.
REQ-014 Port rd_cnt_o  output  8  count of completed OKAY reads.
REQ-015 Port wr_cnt_o  output  8  count of completed OKAY writes.

Function
REQ-016 Storage SHALL be 32 x 32-bit words in two banks: bank0 at BASE_ADDR+0x000..0x03F, bank1 at BASE_ADDR+0x100..0x13F.
REQ-017 An address SHALL be valid iff haddr_i[31:9]==BASE_ADDR[31:9], haddr_i[7:6]==0 and haddr_i[1:0]==0.
REQ-018 For a valid address, word index = {haddr_i[8], haddr_i[5:2]}.
REQ-019 A transfer SHALL be accepted on an edge where hsel_i & hready_i & htrans_i[1] is true; the block latches the index, hwrite_i and validity at that edge.
REQ-020 IDLE or BUSY transfers, or transfers with hsel_i low, SHALL get a zero-wait OKAY response with no state change.
REQ-021 The FSM SHALL have four states: IDLE, DATA, ERR1, ERR2.
REQ-022 Transitions on an accepted valid transfer: go to DATA and load the wait counter with WAIT_CYCLES.
REQ-023 Transitions on an accepted invalid transfer: go to ERR1.
REQ-024 In DATA, hready_o = (wait counter == 0) and hresp_o = 0; the counter decrements each cycle while nonzero.
REQ-025 DATA completes in the cycle where hready_o = 1; the data-phase latency is therefore WAIT_CYCLES+1 cycles.
REQ-026 ERR1 SHALL drive hready_o=0 and hresp_o=1 for one cycle, then go to ERR2.
REQ-027 ERR2 SHALL drive hready_o=1 and hresp_o=1 for one cycle.
REQ-028 An error transfer SHALL NOT modify memory or either counter, and SHALL drive hrdata_o = 0.
REQ-029 For a write, hwdata_i is written to mem[index] at the edge ending the completing DATA cycle.
REQ-030 For a read, hrdata_o = mem[index] during the completing DATA cycle; hrdata_o = 0 in all other cycles.
REQ-031 Pipelining: an address phase presented during a completing DATA or ERR2 cycle SHALL be accepted at the same edge; with back-to-back transfers there are no idle cycles between data phases.
REQ-032 If no new transfer is accepted when DATA or ERR2 completes, the FSM SHALL return to IDLE.
REQ-033 Read-after-write to the same word in consecutive transfers SHALL return the newly written data.
REQ-034 In IDLE, hready_o = 1 and hresp_o = 0.
REQ-035 rd_cnt_o / wr_cnt_o SHALL increment by 1 at each completing OKAY read / write, wrapping 255 -> 0.
REQ-036 Address-phase inputs presented while hready_i = 0 SHALL be ignored.

Reset
REQ-037 While irst = 1 at an edge, the block SHALL enter IDLE and clear all 32 memory words, both counters and the wait counter.
REQ-038 After reset, hready_o = 1, hresp_o = 0 and hrdata_o = 0.
REQ-039 A reset asserted mid-transfer SHALL abort it: no memory write and no counter update.

Verification
REQ-040 Single read, WAIT_CYCLES=1: NONSEQ read of 0x1A04 after reset -> hready_o low for 1 cycle, then hrdata_o=0 with hready_o=1; rd_cnt_o=1.
REQ-041 4-beat burst, WAIT_CYCLES=0: write 0x11,0x22,0x33,0x44 to 0x1B00..0x1B0C back-to-back, then read them back -> hready_o stays high throughout, data matches, wr_cnt_o=4 and rd_cnt_o=4.
REQ-042 Error: read 0x1A40, then write 0x2000 -> each gets hready_o 0 then 1 with hresp_o=1 on both cycles; memory unchanged; counters unchanged.
REQ-043 Read-after-write: write 0xDEADBEEF to 0x1A3C, then immediately read 0x1A3C -> returns 0xDEADBEEF.
REQ-044 Reset mid-operation: assert irst during the wait state of a write to 0x1B04 -> a later read of 0x1B04 returns 0, and wr_cnt_o=0.
REQ-045 Counter wrap: perform 256 reads -> rd_cnt_o=0; IDLE/BUSY cycles interleaved between them get zero-wait OKAY and do not change the count.
